booth_inv_divider: RTL and testbench

Sequential radix-2 restoring divider, the inverse of the team's 8x8 Booth/Wallace hybrid multiplier. It takes a 2W-bit dividend (product width) and a W-bit divisor, and returns a W-bit quotient and a W-bit remainder. Quotient and remainder use truncating semantics: the remainder takes the sign of the dividend. It sits beside the multiplier in the arithmetic datapath and exchanges operands and results through valid/ready handshakes.

---
 rtl/booth_div_pkg.sv | 20 ++
 rtl/booth_inv_divider_div_step.sv | 26 ++
 rtl/booth_inv_divider.sv | 184 ++++++++++++++++++
 tb/tb_booth_inv_divider.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/booth_div_pkg.sv
// Shared types and constants for the restoring divider that pairs with the
// Booth/Wallace multiplier.
package booth_div_pkg;

  localparam int DIV_W     = 8;
  localparam int DIV_CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_inv_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor magnitude when it fits.
module div_step
  import booth_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   r,
  input  logic         bit_in,
  input  logic [W-1:0] d,
  output logic [W:0]   r_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] d_ext;

  always_comb begin
    shifted = {r[W-1:0], bit_in};
    d_ext   = {1'b0, d};
    // r[W] set would mean the shifted value exceeds W+1 bits, so it always fits.
    q_bit   = r[W] | (shifted >= d_ext);
    r_next  = q_bit ? (shifted - d_ext) : shifted;
  end

endmodule

// File: rtl/booth_inv_divider.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor.
// Define BOOTH_DIV_SIGNED_EN for two's-complement operation; unsigned otherwise.
module booth_inv_divider
  import booth_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dbz
);

  localparam int CW = cnt_width(W);

  state_t state_reg, state_next;
  logic alive_reg;

  logic [2*W-1:0] dividend_reg;
  logic [W-1:0]   divisor_reg;
  logic           sign_n_reg, sign_d_reg;
  logic [W-1:0]   mag_d_reg;
  logic [W:0]     r_reg;
  logic [W-1:0]   lo_reg;
  logic [W-1:0]   q_reg;
  logic [CW-1:0]  cnt_reg;

  logic [W-1:0] quotient_reg, remainder_reg;
  logic         ovf_reg, dbz_reg;

  logic           sign_n, sign_d;
  logic [2*W-1:0] mag_n;
  logic [W-1:0]   mag_d;
  logic           prep_dbz, prep_ovf;
  logic [W:0]     step_r;
  logic           step_q;
  logic           q_neg;
  logic [W-1:0]   fix_q, fix_r;
  logic           fix_ovf;

`ifdef BOOTH_DIV_SIGNED_EN
  localparam logic [W-1:0] Q_MIN_MAG = {1'b1, {(W-1){1'b0}}};
  assign sign_n = dividend_reg[2*W-1];
  assign sign_d = divisor_reg[W-1];
`else
  assign sign_n = 1'b0;
  assign sign_d = 1'b0;
`endif

  // Magnitude of -2^(2W-1) still fits 2W bits when read as unsigned.
  assign mag_n    = sign_n ? (~dividend_reg + (2*W)'(1)) : dividend_reg;
  assign mag_d    = sign_d ? (~divisor_reg + W'(1)) : divisor_reg;
  assign prep_dbz = (divisor_reg == '0);
  assign prep_ovf = (mag_n[2*W-1:W] >= mag_d);

  div_step #(.W(W)) u_step (
    .r      (r_reg),
    .bit_in (lo_reg[W-1]),
    .d      (mag_d_reg),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  assign q_neg = sign_n_reg ^ sign_d_reg;
  assign fix_q = q_neg ? (~q_reg + W'(1)) : q_reg;
  assign fix_r = sign_n_reg ? (~r_reg[W-1:0] + W'(1)) : r_reg[W-1:0];

`ifdef BOOTH_DIV_SIGNED_EN
  // -2^(W-1) is representable; +2^(W-1) is not.
  assign fix_ovf = (!q_neg && q_reg[W-1]) || (q_neg && (q_reg > Q_MIN_MAG));
`else
  assign fix_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = alive_reg;
        if (in_valid && alive_reg) state_next = PREP;
      end
      PREP: state_next = (prep_dbz || prep_ovf) ? DONE : CALC;
      CALC: if (cnt_reg == CW'(W - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_reg     <= 1'b0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      sign_n_reg    <= 1'b0;
      sign_d_reg    <= 1'b0;
      mag_d_reg     <= '0;
      r_reg         <= '0;
      lo_reg        <= '0;
      q_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      ovf_reg       <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (in_valid && alive_reg) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
          end
        end
        PREP: begin
          sign_n_reg <= sign_n;
          sign_d_reg <= sign_d;
          mag_d_reg  <= mag_d;
          r_reg      <= {1'b0, mag_n[2*W-1:W]};
          lo_reg     <= mag_n[W-1:0];
          q_reg      <= '0;
          cnt_reg    <= '0;
          if (prep_dbz) begin
            quotient_reg  <= '1;
            remainder_reg <= dividend_reg[W-1:0];
            dbz_reg       <= 1'b1;
            ovf_reg       <= 1'b0;
          end else if (prep_ovf) begin
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b1;
          end
        end
        CALC: begin
          r_reg   <= step_r;
          q_reg   <= {q_reg[W-2:0], step_q};
          lo_reg  <= {lo_reg[W-2:0], 1'b0};
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          dbz_reg <= 1'b0;
          if (fix_ovf) begin
            ovf_reg       <= 1'b1;
            quotient_reg  <= '0;
            remainder_reg <= '0;
          end else begin
            ovf_reg       <= 1'b0;
            quotient_reg  <= fix_q;
            remainder_reg <= fix_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign ovf       = ovf_reg;
  assign dbz       = dbz_reg;

endmodule

// File: tb/tb_booth_inv_divider.sv
// Directed-vector bench for booth_inv_divider; expectations follow the
// BOOTH_DIV_SIGNED_EN setting of the build.
module tb_booth_inv_divider;

`ifdef BOOTH_DIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_inv_divider #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_quotient"}, quotient, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_dbz"}, dbz, 0);
  endtask

  task automatic do_op(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                       input logic [7:0] eq, input logic [7:0] er, input logic eovf,
                       input logic edbz, input int elat, input int hold);
    int lat;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'hA5A5;
    divisor  = 8'h5A;
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid || lat >= 40) break;
    end
    check({name, "_out_valid"}, out_valid, 1);
    check({name, "_latency"}, lat, elat);
    check({name, "_quotient"}, quotient, eq);
    check({name, "_remainder"}, remainder, er);
    check({name, "_ovf"}, ovf, eovf);
    check({name, "_dbz"}, dbz, edbz);
    check({name, "_busy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_q"}, quotient, eq);
      check({name, "_hold_r"}, remainder, er);
      check({name, "_hold_ready"}, in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_drop_valid"}, out_valid, 0);
    check({name, "_back_idle"}, in_ready, 1);
    check({name, "_kept_q"}, quotient, eq);
    $display("op %s dvd=%h dvs=%h q=%h r=%h ovf=%b dbz=%b lat=%0d",
             name, dvd, dvs, quotient, remainder, ovf, dbz, lat);
  endtask

  initial begin
    #3;
    check_idle_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_ready", in_ready, 1);
    check("reset_release_valid", out_valid, 0);

    do_op("d100_7", 16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 10, 0);
    if (SIGNED) do_op("neg100_7", 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 10, 0);
    else        do_op("neg100_7", 16'hFF9C, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 1, 0);
    do_op("dbz", 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b0, 1'b1, 1, 0);
    do_op("ovf_prep", 16'h4000, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1, 0);
    if (SIGNED) do_op("qmin", 16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 10, 0);
    else        do_op("qmin", 16'hFF80, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1, 0);
    if (SIGNED) do_op("ovf_fix", 16'hFF80, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 10, 0);
    else        do_op("ovf_fix", 16'hFF80, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1, 0);
    do_op("hold", 16'h0C35, 8'h19, 8'h7D, 8'h00, 1'b0, 1'b0, 10, 5);
    do_op("b2b", 16'h0400, 8'h0B, 8'h5D, 8'h01, 1'b0, 1'b0, 10, 0);

    // Abort in the fourth CALC iteration; outputs still hold the previous result.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'h00FF;
    divisor  = 8'h10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_zero("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_release_ready", in_ready, 1);
    check("abort_release_valid", out_valid, 0);
    do_op("d255_16", 16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
